// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for the 5-stage core.
// Generates PC / pipeline-register load enables and bubble (flush) controls
// from three events in priority order: data-memory wait, taken branch and
// RAW hazard. Also keeps saturating stall/flush counters for measurement.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Fwd_EN,
    input  logic [3:0]       Src1,
    input  logic [3:0]       Src2,
    input  logic             Src1_Valid,
    input  logic             Two_Src,
    input  logic [3:0]       EXE_Dest,
    input  logic             EXE_WB_EN,
    input  logic             EXE_MEM_R_EN,
    input  logic [3:0]       MEM_Dest,
    input  logic             MEM_WB_EN,
    input  logic             Branch_Taken,
    input  logic             Mem_Req,
    input  logic             Mem_Ready,
    output logic             PC_LD,
    output logic             IF_ID_LD,
    output logic             IF_ID_Flush,
    output logic             ID_EXE_LD,
    output logic             ID_EXE_Flush,
    output logic             EXE_MEM_LD,
    output logic             MEM_WB_LD,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    // Count loaded after a taken branch: cycles of IF/ID flushing still owed.
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic       MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_wait;
    logic exe_writes;
    logic mem_writes;
    logic hit1;
    logic hit2;
    logic hazard;
    logic branch_accept;

    // Hazard detection: with forwarding only a load in EXE can't be bypassed.
    always_comb begin
        mem_wait   = Mem_Req & ~Mem_Ready;
        exe_writes = Fwd_EN ? (EXE_WB_EN & EXE_MEM_R_EN) : EXE_WB_EN;
        mem_writes = ~Fwd_EN & MEM_WB_EN;
        hit1       = Src1_Valid & ((exe_writes & (Src1 == EXE_Dest)) |
                                   (mem_writes & (Src1 == MEM_Dest)));
        hit2       = Two_Src    & ((exe_writes & (Src2 == EXE_Dest)) |
                                   (mem_writes & (Src2 == MEM_Dest)));
        hazard     = hit1 | hit2;
    end

    // Next state, flush count and pipeline controls; memory wait > branch > hazard.
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        branch_accept = 1'b0;
        PC_LD         = 1'b1;
        IF_ID_LD      = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EXE_LD     = 1'b1;
        ID_EXE_Flush  = 1'b0;
        EXE_MEM_LD    = 1'b1;
        MEM_WB_LD     = 1'b1;

        if (!RST) begin
            PC_LD        = 1'b0;
            IF_ID_LD     = 1'b0;
            ID_EXE_LD    = 1'b0;
            EXE_MEM_LD   = 1'b0;
            MEM_WB_LD    = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EXE_Flush = 1'b1;
            state_d      = RUN;
            fcnt_d       = 4'd0;
        end else if (mem_wait) begin
            // Freeze everything; any outstanding flush count is kept for later.
            PC_LD      = 1'b0;
            IF_ID_LD   = 1'b0;
            ID_EXE_LD  = 1'b0;
            EXE_MEM_LD = 1'b0;
            MEM_WB_LD  = 1'b0;
            state_d    = MEM_WAIT;
        end else begin
            case (state_q)
                MEM_WAIT: begin
                    // Access completes: one full-advance cycle, then resume flushing if owed.
                    state_d = (fcnt_q != 4'd0) ? BR_FLUSH : RUN;
                end
                BR_FLUSH: begin
                    if (Branch_Taken) begin
                        IF_ID_Flush   = 1'b1;
                        ID_EXE_Flush  = 1'b1;
                        branch_accept = 1'b1;
                        fcnt_d        = FLUSH_RELOAD;
                        state_d       = MULTI_FLUSH ? BR_FLUSH : RUN;
                    end else begin
                        IF_ID_Flush = 1'b1;
                        fcnt_d      = fcnt_q - 4'd1;
                        if (fcnt_q <= 4'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    if (Branch_Taken) begin
                        IF_ID_Flush   = 1'b1;
                        ID_EXE_Flush  = 1'b1;
                        branch_accept = 1'b1;
                        if (MULTI_FLUSH) begin
                            fcnt_d  = FLUSH_RELOAD;
                            state_d = BR_FLUSH;
                        end
                    end else if (hazard) begin
                        // Hold PC and IF/ID, inject a bubble into ID/EXE.
                        PC_LD        = 1'b0;
                        IF_ID_LD     = 1'b0;
                        ID_EXE_Flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PC_LD && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_accept && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= RUN;
            fcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (3-cycle flush / 16-bit counters
// and 1-cycle flush / 4-bit counters) share one stimulus stream and are
// compared each cycle against an event-level reference model, plus a vector
// table and hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       rst;
    logic       fwd_en, src1_valid, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       branch_taken, mem_req, mem_ready;
    logic [3:0] src1, src2, exe_dest, mem_dest;

    logic        u0_pc_ld, u0_ifid_ld, u0_ifid_fl, u0_idexe_ld, u0_idexe_fl, u0_exmem_ld, u0_memwb_ld;
    logic [15:0] u0_stall, u0_flush;
    logic        u1_pc_ld, u1_ifid_ld, u1_ifid_fl, u1_idexe_ld, u1_idexe_fl, u1_exmem_ld, u1_memwb_ld;
    logic [3:0]  u1_stall, u1_flush;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u0 (
        .CLK(clk), .RST(rst), .Fwd_EN(fwd_en), .Src1(src1), .Src2(src2),
        .Src1_Valid(src1_valid), .Two_Src(two_src), .EXE_Dest(exe_dest),
        .EXE_WB_EN(exe_wb_en), .EXE_MEM_R_EN(exe_mem_r_en), .MEM_Dest(mem_dest),
        .MEM_WB_EN(mem_wb_en), .Branch_Taken(branch_taken), .Mem_Req(mem_req),
        .Mem_Ready(mem_ready), .PC_LD(u0_pc_ld), .IF_ID_LD(u0_ifid_ld),
        .IF_ID_Flush(u0_ifid_fl), .ID_EXE_LD(u0_idexe_ld), .ID_EXE_Flush(u0_idexe_fl),
        .EXE_MEM_LD(u0_exmem_ld), .MEM_WB_LD(u0_memwb_ld),
        .Stall_Cnt(u0_stall), .Flush_Cnt(u0_flush)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u1 (
        .CLK(clk), .RST(rst), .Fwd_EN(fwd_en), .Src1(src1), .Src2(src2),
        .Src1_Valid(src1_valid), .Two_Src(two_src), .EXE_Dest(exe_dest),
        .EXE_WB_EN(exe_wb_en), .EXE_MEM_R_EN(exe_mem_r_en), .MEM_Dest(mem_dest),
        .MEM_WB_EN(mem_wb_en), .Branch_Taken(branch_taken), .Mem_Req(mem_req),
        .Mem_Ready(mem_ready), .PC_LD(u1_pc_ld), .IF_ID_LD(u1_ifid_ld),
        .IF_ID_Flush(u1_ifid_fl), .ID_EXE_LD(u1_idexe_ld), .ID_EXE_Flush(u1_idexe_fl),
        .EXE_MEM_LD(u1_exmem_ld), .MEM_WB_LD(u1_memwb_ld),
        .Stall_Cnt(u1_stall), .Flush_Cnt(u1_flush)
    );

    // Control bits packed {PC, IFID_LD, IFID_FL, IDEXE_LD, IDEXE_FL, EXMEM, MEMWB}
    logic [6:0] ctl0, ctl1;
    assign ctl0 = {u0_pc_ld, u0_ifid_ld, u0_ifid_fl, u0_idexe_ld, u0_idexe_fl, u0_exmem_ld, u0_memwb_ld};
    assign ctl1 = {u1_pc_ld, u1_ifid_ld, u1_ifid_fl, u1_idexe_ld, u1_idexe_fl, u1_exmem_ld, u1_memwb_ld};

    localparam logic [6:0] C_RST   = 7'b0010100;
    localparam logic [6:0] C_WAIT  = 7'b0000000;
    localparam logic [6:0] C_RUN   = 7'b1101011;
    localparam logic [6:0] C_BR    = 7'b1111111;
    localparam logic [6:0] C_FL    = 7'b1111011;
    localparam logic [6:0] C_STALL = 7'b0001111;

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Event view of the controller: one event per cycle chosen by priority.
    localparam int EV_RST = 0, EV_WAIT = 1, EV_REL = 2, EV_BR = 3, EV_FL = 4, EV_STALL = 5, EV_RUN = 6;

    int m_fc[2]  = '{3, 1};
    int m_max[2] = '{65535, 15};
    bit m_wait[2];
    int m_left[2];
    int m_stall[2];
    int m_flush[2];
    int ev_now[2];

    function automatic bit model_hazard();
        logic [15:0] pend;
        pend = '0;
        if (exe_wb_en && (!fwd_en || exe_mem_r_en)) pend[exe_dest] = 1'b1;
        if (mem_wb_en && !fwd_en)                   pend[mem_dest] = 1'b1;
        return (src1_valid && pend[src1]) || (two_src && pend[src2]);
    endfunction

    function automatic int model_event(int i);
        if (!rst)                    return EV_RST;
        if (mem_req && !mem_ready)   return EV_WAIT;
        if (m_wait[i])               return EV_REL;
        if (branch_taken)            return EV_BR;
        if (m_left[i] > 0)           return EV_FL;
        if (model_hazard())          return EV_STALL;
        return EV_RUN;
    endfunction

    function automatic logic [6:0] ev_ctl(int ev);
        case (ev)
            EV_RST:   return C_RST;
            EV_WAIT:  return C_WAIT;
            EV_BR:    return C_BR;
            EV_FL:    return C_FL;
            EV_STALL: return C_STALL;
            default:  return C_RUN;
        endcase
    endfunction

    // Sample just after inputs settle (well away from the rising edge) and compare.
    task automatic settle();
        #1;
        for (int i = 0; i < 2; i++) ev_now[i] = model_event(i);
        check("ctl_u0", 32'(ctl0), 32'(ev_ctl(ev_now[0])));
        check("ctl_u1", 32'(ctl1), 32'(ev_ctl(ev_now[1])));
        check("stall_cnt_u0", 32'(u0_stall), 32'(m_stall[0]));
        check("flush_cnt_u0", 32'(u0_flush), 32'(m_flush[0]));
        check("stall_cnt_u1", 32'(u1_stall), 32'(m_stall[1]));
        check("flush_cnt_u1", 32'(u1_flush), 32'(m_flush[1]));
    endtask

    // Clock edge: advance model, then return to the falling edge for driving.
    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            case (ev_now[i])
                EV_RST: begin
                    m_wait[i] = 1'b0; m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
                end
                EV_WAIT: begin
                    m_wait[i] = 1'b1;
                    if (m_stall[i] < m_max[i]) m_stall[i]++;
                end
                EV_REL:  m_wait[i] = 1'b0;
                EV_BR: begin
                    if (m_flush[i] < m_max[i]) m_flush[i]++;
                    m_left[i] = m_fc[i] - 1;
                end
                EV_FL:   m_left[i]--;
                EV_STALL: if (m_stall[i] < m_max[i]) m_stall[i]++;
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        fwd_en = 0; src1 = 0; src2 = 0; src1_valid = 0; two_src = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        settle(); advance();
        rst = 1;
    endtask

    task automatic cyc();
        settle(); advance();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int fwd, s1, s1v, s2, two, ed, ewb, emr, md, mwb, mreq, mrdy;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl[14];

    // ---------------- main test ----------------
    initial begin
        rst = 0;
        idle();
        @(negedge clk);

        // Reset held 3 cycles with a branch pending.
        branch_taken = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("rst_ctl", 32'(ctl0), 32'(C_RST));
            check("rst_stall", 32'(u0_stall), 32'd0);
            check("rst_flush", 32'(u0_flush), 32'd0);
            advance();
        end
        rst = 1;
        idle();
        settle();
        check("post_rst_ctl", 32'(ctl0), 32'(C_RUN));
        advance();

        // One-cycle vectors applied from RUN: {fwd,s1,s1v,s2,two,ed,ewb,emr,md,mwb,mreq,mrdy,exp}
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN};
        tbl[1]  = '{0, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, C_STALL};
        tbl[2]  = '{1, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, C_RUN};
        tbl[3]  = '{1, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, C_STALL};
        tbl[4]  = '{0, 0, 0, 5, 1, 0, 0, 0, 5, 1, 0, 0, C_STALL};
        tbl[5]  = '{1, 0, 0, 5, 1, 0, 0, 0, 5, 1, 0, 0, C_RUN};
        tbl[6]  = '{0, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, C_RUN};
        tbl[7]  = '{0, 3, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, C_RUN};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN};
        tbl[9]  = '{0, 0, 0, 7, 0, 7, 1, 0, 0, 0, 0, 0, C_RUN};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_STALL};
        tbl[11] = '{0, 15, 1, 0, 0, 0, 0, 0, 15, 1, 0, 0, C_STALL};
        tbl[12] = '{1, 9, 1, 9, 1, 2, 1, 1, 9, 1, 0, 0, C_RUN};
        tbl[13] = '{1, 0, 0, 6, 1, 6, 1, 1, 0, 0, 1, 1, C_STALL};
        for (int v = 0; v < 14; v++) begin
            fwd_en = 1'(tbl[v].fwd); src1 = 4'(tbl[v].s1); src1_valid = 1'(tbl[v].s1v);
            src2 = 4'(tbl[v].s2); two_src = 1'(tbl[v].two); exe_dest = 4'(tbl[v].ed);
            exe_wb_en = 1'(tbl[v].ewb); exe_mem_r_en = 1'(tbl[v].emr);
            mem_dest = 4'(tbl[v].md); mem_wb_en = 1'(tbl[v].mwb);
            mem_req = 1'(tbl[v].mreq); mem_ready = 1'(tbl[v].mrdy);
            settle();
            check($sformatf("vec%0d_u0", v), 32'(ctl0), 32'(tbl[v].exp));
            check($sformatf("vec%0d_u1", v), 32'(ctl1), 32'(tbl[v].exp));
            advance();
        end

        // Single RAW stall counts once; forwarding without a load does not stall.
        do_reset();
        src1 = 3; src1_valid = 1; exe_dest = 3; exe_wb_en = 1;
        cyc();
        idle();
        settle();
        check("raw_stall_cnt", 32'(u0_stall), 32'd1);
        advance();
        src1 = 3; src1_valid = 1; exe_dest = 3; exe_wb_en = 1; fwd_en = 1;
        settle();
        check("fwd_no_stall", 32'(ctl0), 32'(C_RUN));
        advance();
        idle();
        settle();
        check("fwd_stall_cnt", 32'(u0_stall), 32'd1);
        advance();

        // Four-cycle memory wait then completion.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("memwait_ctl", 32'(ctl0), 32'(C_WAIT));
            advance();
        end
        mem_ready = 1;
        settle();
        check("memdone_ctl", 32'(ctl0), 32'(C_RUN));
        advance();
        idle();
        settle();
        check("memwait_stall_cnt", 32'(u0_stall), 32'd4);
        check("memwait_back_run", 32'(ctl0), 32'(C_RUN));
        advance();

        // Taken branch with a 3-cycle flush window.
        do_reset();
        branch_taken = 1;
        settle();
        check("br_c0", 32'(ctl0), 32'(C_BR));
        advance();
        idle();
        for (int k = 1; k <= 2; k++) begin
            settle();
            check($sformatf("br_c%0d", k), 32'(ctl0), 32'(C_FL));
            advance();
        end
        settle();
        check("br_end", 32'(ctl0), 32'(C_RUN));
        check("br_flush_cnt", 32'(u0_flush), 32'd1);
        advance();

        // Memory wait interrupting the flush window keeps the remaining count.
        do_reset();
        branch_taken = 1;
        cyc();
        idle();
        mem_req = 1;
        for (int k = 0; k < 2; k++) begin
            settle();
            check("brwait_ctl", 32'(ctl0), 32'(C_WAIT));
            advance();
        end
        mem_ready = 1;
        settle();
        check("brwait_release", 32'(ctl0), 32'(C_RUN));
        advance();
        idle();
        for (int k = 0; k < 2; k++) begin
            settle();
            check("brwait_resume", 32'(ctl0), 32'(C_FL));
            advance();
        end
        settle();
        check("brwait_end", 32'(ctl0), 32'(C_RUN));
        advance();

        // Branch coincident with a load-use hazard: branch wins, no stall counted.
        do_reset();
        fwd_en = 1; src1 = 4; src1_valid = 1; exe_dest = 4; exe_wb_en = 1; exe_mem_r_en = 1;
        branch_taken = 1;
        settle();
        check("br_haz_u0", 32'(ctl0), 32'(C_BR));
        check("br_haz_u1", 32'(ctl1), 32'(C_BR));
        advance();
        idle();
        settle();
        check("br_haz_stall", 32'(u0_stall), 32'd0);
        check("br_haz_flush", 32'(u0_flush), 32'd1);
        advance();

        // Saturation of the 4-bit stall counter.
        do_reset();
        mem_req = 1;
        for (int k = 0; k < 20; k++) cyc();
        idle();
        settle();
        check("sat_u1_stall", 32'(u1_stall), 32'd15);
        check("sat_u0_stall", 32'(u0_stall), 32'd20);
        advance();

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            rst          = ($urandom_range(0, 49) != 0);
            fwd_en       = 1'($urandom_range(0, 1));
            src1         = 4'($urandom_range(0, 3));
            src2         = 4'($urandom_range(0, 3));
            src1_valid   = 1'($urandom_range(0, 1));
            two_src      = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog against a stuck simulation.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
